spw_tx_credit: RTL
==================

SPW_TX_CREDIT -- requirements
Module: spw_tx_credit

Interface
REQ-001 SHALL provide parameter CREDIT_MAX, default 56, max credit the transmitter may hold.
REQ-002 SHALL provide parameter FCT_INC, default 8, credit added per received FCT.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 16'd6400, starvation limit in CLOCK cycles.
REQ-004 SHALL have port CLOCK  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enableTx  input  1  link in Run state; low blocks transmission.
REQ-007 SHALL have port gotFct  input  1  one-cycle pulse per FCT received from the remote end.
REQ-008 SHALL have port ncharValid  input  1  TX FIFO holds an N-Char ready to send.
REQ-009 SHALL have port ncharReq  output  1  request to the encoder to send one N-Char.
REQ-010 SHALL have port ncharAck  input  1  one-cycle pulse, encoder accepted the N-Char.
REQ-011 SHALL have port credit  output  7  current transmit credit.
REQ-012 SHALL have port creditErr  output  1  registered, sticky credit error.
REQ-013 SHALL have port creditTimeout  output  1  one-cycle pulse on credit starvation.

Function
REQ-014 SHALL register enableTx into enableTx_d; fall = !enableTx & enableTx_d.
REQ-015 SHALL implement states TX_IDLE, TX_REQ, TX_SENT.
REQ-016 TX_IDLE -> TX_REQ when enableTx & ncharValid & credit != 0; otherwise stay.
REQ-017 TX_REQ -> TX_SENT on ncharAck; otherwise stay. ncharReq = 1 only in TX_REQ.
REQ-018 TX_SENT -> TX_IDLE unconditionally, giving at least one idle cycle between N-Chars.
REQ-019 On fall, state SHALL go to TX_IDLE next cycle, overriding every other transition.
REQ-020 credit update, one cycle after the event:
- ncharAck alone: -1.
- gotFct alone: +FCT_INC.
- both together: +FCT_INC-1.
REQ-021 gotFct with credit + FCT_INC > CREDIT_MAX SHALL set creditErr and discard the increment; a simultaneous ncharAck decrement still applies.
REQ-022 ncharAck while credit == 0 or state != TX_REQ SHALL set creditErr and leave credit unchanged.
REQ-023 creditErr SHALL stay set until fall or reset.
REQ-024 On fall, credit and creditErr SHALL clear next cycle; gotFct/ncharAck in that cycle are ignored.
REQ-025 credit arithmetic SHALL be 7-bit unsigned and never wrap; it stays in 0..CREDIT_MAX.
REQ-026 gotFct SHALL be accepted in any state, including while enableTx is low.

Reset
REQ-027 On RESETn low, the following SHALL clear asynchronously: state to TX_IDLE; credit, creditErr, ncharReq, creditTimeout, enableTx_d and the timeout counter to 0.
REQ-028 Reset de-assertion mid-operation SHALL resume from TX_IDLE with zero credit; pending requests are dropped.

Configuration
REQ-029 Macro SPW_TX_CREDIT_TIMEOUT_EN SHALL gate the starvation timer.
REQ-030 With SPW_TX_CREDIT_TIMEOUT_EN defined, behaviour SHALL be:
- counter increments each cycle with enableTx & ncharValid & credit == 0.
- counter clears otherwise.
- creditTimeout pulses one cycle when the counter reaches TIMEOUT_CYCLES, then the counter clears.
REQ-031 Without the macro, no counter SHALL be built and creditTimeout SHALL be tied to 0.

Verification
REQ-032 Reset, enableTx=1, ncharValid=1, no FCT -> ncharReq stays 0, credit=0, creditErr=0.
REQ-033 One gotFct, then 8 ncharAck handshakes -> credit 8,7..0, then ncharReq stays 0, no error.
REQ-034 Seven gotFct pulses (credit 56), then an eighth -> credit stays 56, creditErr=1 next cycle.
REQ-035 credit=5 with gotFct and ncharAck in the same cycle -> credit=12, state TX_SENT.
REQ-036 credit=24 and creditErr=1, enableTx 1->0 -> next cycle credit=0, creditErr=0, state TX_IDLE.
REQ-037 Macro defined, TIMEOUT_CYCLES=10, credit=0, ncharValid=1 for 12 cycles -> single creditTimeout pulse at cycle 10; macro undefined -> never pulses.

Source files
------------

// File: rtl/spw_tx_credit.sv
// rtl/spw_tx_credit.sv - SpaceWire transmit credit counter and N-Char request FSM.
// Optional starvation timer built only when SPW_TX_CREDIT_TIMEOUT_EN is defined.
module spw_tx_credit #(
    parameter int          CREDIT_MAX     = 56,
    parameter int          FCT_INC        = 8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd6400
) (
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic       enableTx,
    input  logic       gotFct,
    input  logic       ncharValid,
    output logic       ncharReq,
    input  logic       ncharAck,
    output logic [6:0] credit,
    output logic       creditErr,
    output logic       creditTimeout
);
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_SENT = 2'd2
    } state_t;

    localparam logic [7:0] INC_W = 8'(FCT_INC);
    localparam logic [7:0] MAX_W = 8'(CREDIT_MAX);

    state_t     state_q, state_d;
    logic       enableTx_d;
    logic       fall;
    logic [6:0] credit_q, credit_d;
    logic       err_q, err_d;
    logic       fct_ok, ack_ok;

    assign fall = !enableTx && enableTx_d;

    // An FCT is only honoured if it cannot push credit past CREDIT_MAX.
    assign fct_ok = gotFct && (({1'b0, credit_q} + INC_W) <= MAX_W);
    assign ack_ok = ncharAck && (credit_q != 7'd0) && (state_q == TX_REQ);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        err_d    = err_q;

        case (state_q)
            TX_IDLE: if (enableTx && ncharValid && (credit_q != 7'd0)) state_d = TX_REQ;
            TX_REQ:  if (ncharAck) state_d = TX_SENT;
            TX_SENT: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase

        if ((gotFct && !fct_ok) || (ncharAck && !ack_ok)) err_d = 1'b1;

        credit_d = credit_q + (fct_ok ? INC_W[6:0] : 7'd0) - (ack_ok ? 7'd1 : 7'd0);

        // Leaving Run wipes the credit bookkeeping and ignores same-cycle events.
        if (fall) begin
            state_d  = TX_IDLE;
            credit_d = 7'd0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= TX_IDLE;
            credit_q   <= 7'd0;
            err_q      <= 1'b0;
            enableTx_d <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
            enableTx_d <= enableTx;
        end
    end

    assign ncharReq  = (state_q == TX_REQ);
    assign credit    = credit_q;
    assign creditErr = err_q;

`ifdef SPW_TX_CREDIT_TIMEOUT_EN
    logic        starve;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;

    assign starve = enableTx && ncharValid && (credit_q == 7'd0);

    always_comb begin
        tmo_cnt_d = 16'd0;
        tmo_d     = 1'b0;
        if (starve) begin
            if (tmo_cnt_q == (TIMEOUT_CYCLES - 16'd1)) begin
                tmo_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            tmo_cnt_q <= 16'd0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign creditTimeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo    = |TIMEOUT_CYCLES;
    assign creditTimeout = 1'b0;
`endif

endmodule
